// File: rtl/bus_pkg.sv
// Shared types and constants for the sysbus arbiter slice: bus FSM states,
// requester identifiers, wait-counter width and the round-robin pick rule.
package bus_pkg;

   // Bus access sequence: address phase, strobed data phase, turnaround.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } bus_state_t;

   // Requester identity; also the encoding of the last-grant register.
   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_LDR = 1'b1
   } port_t;

   // Width of the data-phase wait counter (covers WAIT_CYC up to 15).
   localparam int WAIT_W = 4;

   // Two-way round-robin pick: a lone requester always wins; on a tie the
   // port that was not granted last wins.
   function automatic port_t rr_pick(input logic  req_cpu,
                                     input logic  req_ldr,
                                     input port_t last_grant);
      port_t pick;
      case ({req_cpu, req_ldr})
         2'b10:   pick = PORT_CPU;
         2'b01:   pick = PORT_LDR;
         2'b11:   pick = (last_grant == PORT_CPU) ? PORT_LDR : PORT_CPU;
         default: pick = PORT_CPU;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Requester-side handshake bundle. One instance per requester (CPU, loader).
// master = requester side, slave = arbiter side.
interface sysbus_arbiter_if #(
   parameter int WORD_W = 8
) ();

   logic              req;
   logic              we;
   logic [WORD_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] rdata;
   logic              ack;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pick is combinational from the requests
// and the last-grant register; the register only moves when the FSM accepts
// the pick, so an unserved tie keeps its priority order.
module rr_arbiter2
   import bus_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  logic  req_cpu,
   input  logic  req_ldr,
   input  logic  update_en,
   output logic  any_req,
   output port_t grant
);

   port_t last_grant_r;

   assign any_req = req_cpu | req_ldr;

   // Pick the winner for this cycle from requests and last grant.
   always_comb begin
      grant = rr_pick(req_cpu, req_ldr, last_grant_r);
   end

   // Remember the accepted grant; reset favours the CPU on the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_r <= PORT_LDR;
      end else if (update_en && any_req) begin
         last_grant_r <= grant;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Memory-bus controller sharing the multiplexed sysbus and external RAM
// between the CPU sequencer and the loader/debug port. Each access is an
// address phase (RAM_ADDRCP pulse), a strobed data phase of WAIT_CYC cycles
// and a one-cycle turnaround that returns the ack. Every output, including
// the sysbus driver enable, comes straight from a flop so no request input
// can reach a strobe or the bus combinationally. WAIT_CYC must be 1..15.
module sysbus_arbiter
   import bus_pkg::*;
#(
   parameter int WORD_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic              clock,
   input  logic              reset,
   sysbus_arbiter_if.slave   cpu,
   sysbus_arbiter_if.slave   ldr,
   output logic              RAM_NCE,
   output logic              RAM_NOE,
   output logic              RAM_NWE,
   output logic              RAM_ADDRCP,
   output logic              busy,
   inout  wire  [WORD_W-1:0] sysbus
);

   localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYC - 1);
   localparam logic [WAIT_W-1:0] CNT_ZERO = {WAIT_W{1'b0}};
   localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);

   // Registered state
   bus_state_t        state_r;
   logic [WAIT_W-1:0] cnt_r;
   port_t             grant_r;
   logic              we_r;
   logic [WORD_W-1:0] addr_r;
   logic [WORD_W-1:0] wdata_r;
   logic [WORD_W-1:0] cpu_rdata_r;
   logic [WORD_W-1:0] ldr_rdata_r;
   logic              cpu_ack_r;
   logic              ldr_ack_r;
   logic              nce_r;
   logic              noe_r;
   logic              nwe_r;
   logic              addrcp_r;
   logic              busy_r;
   logic              sysbus_oe_r;
   logic [WORD_W-1:0] sysbus_out_r;

   // Next-state values
   bus_state_t        state_s;
   logic [WAIT_W-1:0] cnt_s;
   port_t             grant_s;
   logic              we_s;
   logic [WORD_W-1:0] addr_s;
   logic [WORD_W-1:0] wdata_s;
   logic [WORD_W-1:0] cpu_rdata_s;
   logic [WORD_W-1:0] ldr_rdata_s;
   logic              cpu_ack_s;
   logic              ldr_ack_s;
   logic              nce_s;
   logic              noe_s;
   logic              nwe_s;
   logic              addrcp_s;
   logic              busy_s;
   logic              sysbus_oe_s;
   logic [WORD_W-1:0] sysbus_out_s;

   // Arbiter interface
   logic              arb_update_s;
   logic              arb_any_req_s;
   port_t             arb_grant_s;

   rr_arbiter2 u_rr_arbiter2 (
      .clock     (clock),
      .reset     (reset),
      .req_cpu   (cpu.req),
      .req_ldr   (ldr.req),
      .update_en (arb_update_s),
      .any_req   (arb_any_req_s),
      .grant     (arb_grant_s)
   );

   // Sequence control: grant and latch the request in IDLE, time the data
   // phase with the wait counter and capture read data on its last cycle.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      grant_s      = grant_r;
      we_s         = we_r;
      addr_s       = addr_r;
      wdata_s      = wdata_r;
      cpu_rdata_s  = cpu_rdata_r;
      ldr_rdata_s  = ldr_rdata_r;
      arb_update_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (arb_any_req_s) begin
               state_s      = ADDR;
               grant_s      = arb_grant_s;
               arb_update_s = 1'b1;
               if (arb_grant_s == PORT_LDR) begin
                  we_s    = ldr.we;
                  addr_s  = ldr.addr;
                  wdata_s = ldr.wdata;
               end else begin
                  we_s    = cpu.we;
                  addr_s  = cpu.addr;
                  wdata_s = cpu.wdata;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ADDR: begin
            cnt_s   = CNT_LOAD;
            state_s = ACCESS;
         end
         ACCESS: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = DONE;
               if (!we_r) begin
                  if (grant_r == PORT_LDR) begin
                     ldr_rdata_s = sysbus;
                  end else begin
                     cpu_rdata_s = sysbus;
                  end
               end else begin
                  cpu_rdata_s = cpu_rdata_r;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Decode next-cycle strobes, bus drive and acks from the next state so
   // they can be registered alongside it.
   always_comb begin
      nce_s        = 1'b1;
      noe_s        = 1'b1;
      nwe_s        = 1'b1;
      addrcp_s     = 1'b0;
      cpu_ack_s    = 1'b0;
      ldr_ack_s    = 1'b0;
      sysbus_oe_s  = 1'b0;
      sysbus_out_s = {WORD_W{1'b0}};
      busy_s       = (state_s != IDLE);
      case (state_s)
         ADDR: begin
            addrcp_s     = 1'b1;
            sysbus_oe_s  = 1'b1;
            sysbus_out_s = addr_s;
         end
         ACCESS: begin
            nce_s = 1'b0;
            if (we_s) begin
               nwe_s        = 1'b0;
               sysbus_oe_s  = 1'b1;
               sysbus_out_s = wdata_s;
            end else begin
               noe_s = 1'b0;
            end
         end
         DONE: begin
            if (grant_s == PORT_LDR) begin
               ldr_ack_s = 1'b1;
            end else begin
               cpu_ack_s = 1'b1;
            end
         end
         IDLE: begin
            busy_s = 1'b0;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops every strobe and releases the bus.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= CNT_ZERO;
         grant_r      <= PORT_CPU;
         we_r         <= 1'b0;
         addr_r       <= {WORD_W{1'b0}};
         wdata_r      <= {WORD_W{1'b0}};
         cpu_rdata_r  <= {WORD_W{1'b0}};
         ldr_rdata_r  <= {WORD_W{1'b0}};
         cpu_ack_r    <= 1'b0;
         ldr_ack_r    <= 1'b0;
         nce_r        <= 1'b1;
         noe_r        <= 1'b1;
         nwe_r        <= 1'b1;
         addrcp_r     <= 1'b0;
         busy_r       <= 1'b0;
         sysbus_oe_r  <= 1'b0;
         sysbus_out_r <= {WORD_W{1'b0}};
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         grant_r      <= grant_s;
         we_r         <= we_s;
         addr_r       <= addr_s;
         wdata_r      <= wdata_s;
         cpu_rdata_r  <= cpu_rdata_s;
         ldr_rdata_r  <= ldr_rdata_s;
         cpu_ack_r    <= cpu_ack_s;
         ldr_ack_r    <= ldr_ack_s;
         nce_r        <= nce_s;
         noe_r        <= noe_s;
         nwe_r        <= nwe_s;
         addrcp_r     <= addrcp_s;
         busy_r       <= busy_s;
         sysbus_oe_r  <= sysbus_oe_s;
         sysbus_out_r <= sysbus_out_s;
      end
   end

   assign sysbus     = sysbus_oe_r ? sysbus_out_r : {WORD_W{1'bz}};
   assign RAM_NCE    = nce_r;
   assign RAM_NOE    = noe_r;
   assign RAM_NWE    = nwe_r;
   assign RAM_ADDRCP = addrcp_r;
   assign busy       = busy_r;
   assign cpu.rdata  = cpu_rdata_r;
   assign cpu.ack    = cpu_ack_r;
   assign ldr.rdata  = ldr_rdata_r;
   assign ldr.ack    = ldr_ack_r;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: a WAIT_CYC=2 instance with a RAM model
// on sysbus, plus WAIT_CYC=1 and WAIT_CYC=15 instances for latency.
module tb_sysbus_arbiter;

   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clock = ~clock;

   sysbus_arbiter_if #(.WORD_W(8)) cpu_if ();
   sysbus_arbiter_if #(.WORD_W(8)) ldr_if ();
   sysbus_arbiter_if #(.WORD_W(8)) cpu_w1_if ();
   sysbus_arbiter_if #(.WORD_W(8)) ldr_w1_if ();
   sysbus_arbiter_if #(.WORD_W(8)) cpu_w15_if ();
   sysbus_arbiter_if #(.WORD_W(8)) ldr_w15_if ();

   wire  [7:0] sysbus;
   wire  [7:0] sysbus_w1;
   wire  [7:0] sysbus_w15;
   logic ram_nce, ram_noe, ram_nwe, ram_addrcp, busy;
   logic w1_nce, w1_noe, w1_nwe, w1_addrcp, w1_busy;
   logic w15_nce, w15_noe, w15_nwe, w15_addrcp, w15_busy;

   sysbus_arbiter #(.WORD_W(8), .WAIT_CYC(2)) u_dut (
      .clock(clock), .reset(reset), .cpu(cpu_if), .ldr(ldr_if),
      .RAM_NCE(ram_nce), .RAM_NOE(ram_noe), .RAM_NWE(ram_nwe),
      .RAM_ADDRCP(ram_addrcp), .busy(busy), .sysbus(sysbus)
   );

   sysbus_arbiter #(.WORD_W(8), .WAIT_CYC(1)) u_w1 (
      .clock(clock), .reset(reset), .cpu(cpu_w1_if), .ldr(ldr_w1_if),
      .RAM_NCE(w1_nce), .RAM_NOE(w1_noe), .RAM_NWE(w1_nwe),
      .RAM_ADDRCP(w1_addrcp), .busy(w1_busy), .sysbus(sysbus_w1)
   );

   sysbus_arbiter #(.WORD_W(8), .WAIT_CYC(15)) u_w15 (
      .clock(clock), .reset(reset), .cpu(cpu_w15_if), .ldr(ldr_w15_if),
      .RAM_NCE(w15_nce), .RAM_NOE(w15_noe), .RAM_NWE(w15_nwe),
      .RAM_ADDRCP(w15_addrcp), .busy(w15_busy), .sysbus(sysbus_w15)
   );

   // RAM model: address latched on RAM_ADDRCP, written while NCE/NWE low,
   // drives sysbus while NCE/NOE low.
   logic [7:0] mem [0:255];
   logic [7:0] ram_addr_r;
   logic       ram_preset;

   assign sysbus = (!ram_nce && !ram_noe) ? mem[ram_addr_r] : 8'hzz;

   always @(posedge clock) begin
      if (ram_preset) begin
         mem[8'h05] <= 8'hA7;
         mem[8'h1F] <= 8'h00;
         mem[8'h40] <= 8'h00;
         mem[8'h80] <= 8'h11;
      end else begin
         if (ram_addrcp) ram_addr_r <= sysbus;
         if (!ram_nce && !ram_nwe) mem[ram_addr_r] <= sysbus;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pins(input string tag, input logic nce, input logic noe,
                       input logic nwe, input logic acp);
      check({tag, "_nce"}, ram_nce, nce);
      check({tag, "_noe"}, ram_noe, noe);
      check({tag, "_nwe"}, ram_nwe, nwe);
      check({tag, "_addrcp"}, ram_addrcp, acp);
   endtask

   // Bus contention: the block must never drive while RAM_NOE is low, and
   // must release the bus in every ack (DONE) cycle.
   always @(negedge clock) begin
      if (!ram_noe) check("oe_while_noe", u_dut.sysbus_oe_r, 1'b0);
      if (cpu_if.ack || ldr_if.ack) check("oe_in_done", u_dut.sysbus_oe_r, 1'b0);
      if (cpu_w1_if.ack) check("w1_oe_in_done", u_w1.sysbus_oe_r, 1'b0);
      if (cpu_w15_if.ack) check("w15_oe_in_done", u_w15.sysbus_oe_r, 1'b0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n_ack;
      int last_cyc;
      int lat1;
      int lat15;
      logic prev_ack;

      reset = 1'b1;
      ram_preset = 1'b1;
      cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 8'h00; cpu_if.wdata = 8'h00;
      ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = 8'h00; ldr_if.wdata = 8'h00;
      cpu_w1_if.req = 1'b0; cpu_w1_if.we = 1'b0; cpu_w1_if.addr = 8'h00; cpu_w1_if.wdata = 8'h00;
      ldr_w1_if.req = 1'b0; ldr_w1_if.we = 1'b0; ldr_w1_if.addr = 8'h00; ldr_w1_if.wdata = 8'h00;
      cpu_w15_if.req = 1'b0; cpu_w15_if.we = 1'b0; cpu_w15_if.addr = 8'h00; cpu_w15_if.wdata = 8'h00;
      ldr_w15_if.req = 1'b0; ldr_w15_if.we = 1'b0; ldr_w15_if.addr = 8'h00; ldr_w15_if.wdata = 8'h00;

      // Reset state
      repeat (3) @(negedge clock);
      pins("rst", 1'b1, 1'b1, 1'b1, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cpu_ack", cpu_if.ack, 1'b0);
      check("rst_ldr_ack", ldr_if.ack, 1'b0);
      check("rst_cpu_rdata", cpu_if.rdata, 8'h00);
      check("rst_ldr_rdata", ldr_if.rdata, 8'h00);
      check("rst_bus_oe", u_dut.sysbus_oe_r, 1'b0);
      reset = 1'b0;
      ram_preset = 1'b0;

      // CPU read of 0x05, RAM holds 0xA7
      cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 8'h05;
      @(negedge clock);
      pins("rd_c1", 1'b1, 1'b1, 1'b1, 1'b1);
      check("rd_c1_bus", sysbus, 8'h05);
      check("rd_c1_busy", busy, 1'b1);
      @(negedge clock);
      pins("rd_c2", 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clock);
      pins("rd_c3", 1'b0, 1'b0, 1'b1, 1'b0);
      check("rd_c3_ack", cpu_if.ack, 1'b0);
      @(negedge clock);
      pins("rd_c4", 1'b1, 1'b1, 1'b1, 1'b0);
      check("rd_c4_ack", cpu_if.ack, 1'b1);
      check("rd_c4_ldr_ack", ldr_if.ack, 1'b0);
      check("rd_rdata", cpu_if.rdata, 8'hA7);
      cpu_if.req = 1'b0;
      @(negedge clock);
      check("rd_c5_ack", cpu_if.ack, 1'b0);
      check("rd_c5_busy", busy, 1'b0);
      check("rd_c5_rdata_hold", cpu_if.rdata, 8'hA7);

      // Loader write 0x3C to 0x1F
      ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 8'h1F; ldr_if.wdata = 8'h3C;
      @(negedge clock);
      pins("wr_c1", 1'b1, 1'b1, 1'b1, 1'b1);
      check("wr_c1_bus", sysbus, 8'h1F);
      @(negedge clock);
      pins("wr_c2", 1'b0, 1'b1, 1'b0, 1'b0);
      check("wr_c2_bus", sysbus, 8'h3C);
      @(negedge clock);
      pins("wr_c3", 1'b0, 1'b1, 1'b0, 1'b0);
      check("wr_c3_bus", sysbus, 8'h3C);
      @(negedge clock);
      pins("wr_c4", 1'b1, 1'b1, 1'b1, 1'b0);
      check("wr_c4_ack", ldr_if.ack, 1'b1);
      check("wr_c4_cpu_ack", cpu_if.ack, 1'b0);
      ldr_if.req = 1'b0;
      @(negedge clock);
      check("wr_c5_ack", ldr_if.ack, 1'b0);
      check("wr_mem", mem[8'h1F], 8'h3C);
      check("wr_ldr_rdata", ldr_if.rdata, 8'h00);
      check("wr_cpu_rdata", cpu_if.rdata, 8'hA7);

      // Both requesting continuously: CPU, LDR, CPU, LDR, 5 cycles apart
      cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 8'h05;
      ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 8'h40; ldr_if.wdata = 8'h55;
      n_ack = 0; last_cyc = 0; prev_ack = 1'b0;
      for (int cyc = 1; cyc <= 60 && n_ack < 4; cyc++) begin
         @(negedge clock);
         check("rr_dual_ack", cpu_if.ack & ldr_if.ack, 1'b0);
         if (cpu_if.ack || ldr_if.ack) begin
            check("rr_order", ldr_if.ack, n_ack[0]);
            check("rr_pulse", prev_ack, 1'b0);
            if (n_ack > 0) check("rr_gap", cyc - last_cyc, 5);
            last_cyc = cyc;
            n_ack++;
            if (n_ack == 4) begin
               cpu_if.req = 1'b0;
               ldr_if.req = 1'b0;
            end
         end
         prev_ack = cpu_if.ack | ldr_if.ack;
      end
      check("rr_count", n_ack, 4);
      @(negedge clock);
      check("rr_ack_end", cpu_if.ack | ldr_if.ack, 1'b0);
      check("rr_mem", mem[8'h40], 8'h55);
      check("rr_cpu_rdata", cpu_if.rdata, 8'hA7);

      // Reset in the data phase of a CPU write
      cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 8'h80; cpu_if.wdata = 8'h99;
      @(negedge clock);
      @(negedge clock);
      check("rm_access_nwe", ram_nwe, 1'b0);
      reset = 1'b1;
      cpu_if.req = 1'b0;
      @(negedge clock);
      pins("rm", 1'b1, 1'b1, 1'b1, 1'b0);
      check("rm_busy", busy, 1'b0);
      check("rm_bus_oe", u_dut.sysbus_oe_r, 1'b0);
      check("rm_ack", cpu_if.ack | ldr_if.ack, 1'b0);
      check("rm_cpu_rdata", cpu_if.rdata, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("rm_no_ack", cpu_if.ack | ldr_if.ack, 1'b0);
         check("rm_no_nwe", ram_nwe, 1'b1);
      end
      check("rm_mem", (mem[8'h80] == 8'h11) || (mem[8'h80] == 8'h99), 1'b1);

      // Latency at WAIT_CYC=1 and WAIT_CYC=15
      cpu_w1_if.req = 1'b1; cpu_w1_if.we = 1'b1; cpu_w1_if.addr = 8'h22; cpu_w1_if.wdata = 8'h77;
      cpu_w15_if.req = 1'b1; cpu_w15_if.we = 1'b1; cpu_w15_if.addr = 8'h22; cpu_w15_if.wdata = 8'h77;
      lat1 = 0; lat15 = 0;
      for (int n = 1; n <= 40 && (lat1 == 0 || lat15 == 0); n++) begin
         @(negedge clock);
         if (lat1 == 0 && cpu_w1_if.ack) begin
            lat1 = n;
            cpu_w1_if.req = 1'b0;
         end
         if (lat15 == 0 && cpu_w15_if.ack) begin
            lat15 = n;
            cpu_w15_if.req = 1'b0;
         end
      end
      check("lat_w1", lat1, 3);
      check("lat_w15", lat15, 17);
      @(negedge clock);
      check("lat_w15_ack_end", cpu_w15_if.ack, 1'b0);
      check("lat_w15_busy", w15_busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Memory-bus controller that shares the single multiplexed address/data `sysbus` and the external RAM between two requesters.
- Requester A is the CPU sequencer port; requester B is the program loader/debug port, driven from switches or a host.
- Sequences each access as an address phase (`RAM_ADDRCP` latch pulse) followed by a data phase with `RAM_NCE`/`RAM_NOE`/`RAM_NWE` strobes and programmable wait states.
- Sits between the CPU datapath and the RAM pins; becomes the only driver of `sysbus` toward RAM.

Parameters:
- WORD_W, 8, width of sysbus, address and data.
- WAIT_CYC, 2, data-phase strobe length in clock cycles; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  input  WORD_W  access address
- cpu_wdata  input  WORD_W  write data
- cpu_rdata  output  WORD_W  read data, valid from cpu_ack
- cpu_ack  output  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same directions, widths and rules as the cpu_* ports, for the loader
- RAM_NCE  output  1  RAM chip enable, active-low
- RAM_NOE  output  1  RAM output enable, active-low
- RAM_NWE  output  1  RAM write enable, active-low
- RAM_ADDRCP  output  1  address latch pulse, active-high
- busy  output  1  high in any state other than IDLE
- sysbus  inout  WORD_W  shared bus; high-Z whenever this block is not driving it

Behaviour:
- FSM states: IDLE, ADDR, ACCESS, DONE.
- Reset: state = IDLE; wait counter = 0; last-grant = LDR, so the CPU wins the first tie.
- Outputs in reset: RAM_NCE, RAM_NOE and RAM_NWE = 1; RAM_ADDRCP = 0; both acks = 0; both rdata = 0; busy = 0; sysbus high-Z.
- Reset mid-operation: at the next edge all strobes deassert, the bus releases and no ack is issued, whatever the current state.
- IDLE:
  - Both req low: stay in IDLE.
  - One req high: grant that port, register its we/addr/wdata, go to ADDR.
  - Both req high: grant the port not granted last (round-robin), then update last-grant.
- ADDR (1 cycle): drive the registered address on sysbus; RAM_ADDRCP = 1; NCE/NOE/NWE stay 1; load counter with WAIT_CYC-1; go to ACCESS.
- ACCESS (WAIT_CYC cycles): RAM_NCE = 0; RAM_ADDRCP = 0.
  - Read: RAM_NOE = 0, RAM_NWE = 1, sysbus high-Z.
  - Write: RAM_NWE = 0, RAM_NOE = 1, registered wdata driven on sysbus.
  - Counter decrements each cycle. On the cycle the counter is 0: a read captures sysbus into the granted port's rdata register; then go to DONE.
- DONE (1 cycle): all strobes = 1; sysbus high-Z (bus turnaround); granted port's ack = 1; go to IDLE.
- Latency: req first sampled high in IDLE at edge k → ack high in cycle k+2+WAIT_CYC. Minimum spacing between back-to-back transactions is 3+WAIT_CYC cycles.
- Requester rules:
  - req, we, addr and wdata are held stable until ack.
  - req still high in the cycle after ack starts a new transaction; the round-robin still applies.
  - req dropped before grant: request ignored. req dropped after grant: transaction completes and ack is still pulsed.
- rdata holds its value until the next read completes on that port; writes leave rdata unchanged.
- No combinational path from any req to any strobe or to sysbus; all outputs are registered or decoded from state.
- Address wraps naturally at 2^WORD_W; no range checking.

Decomposition:
- Shared package `bus_pkg`:
  - `bus_state_t` enum {IDLE, ADDR, ACCESS, DONE}.
  - `port_t` enum {PORT_CPU, PORT_LDR}.
  - Constant WAIT_W = 4 (counter width).
- Single sub-module `rr_arbiter2`: 2-way round-robin pick with a last-grant register and an update enable from the FSM.
- Tristate driver and FSM stay in the top module.

Test Plan:
- Reset, then CPU read: cpu_req=1, cpu_we=0, cpu_addr=8'h05; RAM model returns 8'hA7 → RAM_ADDRCP pulses with sysbus=8'h05 at k+1; NCE/NOE low k+2..k+3; cpu_ack at k+4; cpu_rdata=8'hA7.
- Loader write: ldr_addr=8'h1F, ldr_wdata=8'h3C → NWE low 2 cycles with sysbus=8'h3C; RAM model holds 8'h3C at 8'h1F; ldr_ack one cycle; NOE stays high throughout.
- Simultaneous req held continuously on both ports for 4 transactions → grants alternate CPU, LDR, CPU, LDR; each ack is exactly one cycle; no two acks in the same cycle.
- reset asserted during ACCESS of a write → next edge: NWE=1, NCE=1, sysbus Z, busy=0, no ack; RAM contents at that address unchanged, or at worst partially written with no further strobe.
- WAIT_CYC=1 versus WAIT_CYC=15 → ack latency exactly 3 and 17 cycles respectively from req sample.
- Bus-contention check: across all tests, assert sysbus is never driven by the block while RAM_NOE=0, and is Z in every DONE cycle.
